shot_scheduler: RTL and testbench
=================================

SHOT_SCHEDULER -- requirements
Module: shot_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, meaning the number of fire requesters (index 0 = player, 1..3 = aliens).
REQ-002 The module SHALL have parameter NUM_SLOTS, default 4, meaning the number of shot engines in the pool.
REQ-003 The module SHALL have parameter COOLDOWN, default 6, meaning the tick count required between grants to one requester.
REQ-004 The module SHALL have port s_clk  input  1  the single system clock; all logic is on its rising edge.
REQ-005 The module SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 The module SHALL have port tick  input  1  one-cycle charge-advance strobe.
REQ-007 The module SHALL have port req  input  NUM_REQ  level fire requests.
REQ-008 The module SHALL have port slot_done  input  NUM_SLOTS  one-cycle pulse when a slot's shot hits or leaves the screen.
REQ-009 The module SHALL have port grant  output  NUM_REQ  one-hot one-cycle grant pulse.
REQ-010 The module SHALL have port grant_slot  output  clog2(NUM_SLOTS)  the slot index carried by the current grant.
REQ-011 The module SHALL have port slot_en  output  NUM_SLOTS  slot-busy flags that drive the shot engine enables.
REQ-012 The module SHALL have port slot_owner  output  NUM_SLOTS*clog2(NUM_REQ)  the flattened owner index of each slot.
REQ-013 The module SHALL have port charge_count  output  3  requester 0 charge level, for the HUD.

Function
REQ-014 Each requester SHALL have a charge counter: 0 on grant, +1 per tick, saturating at COOLDOWN; requester ready iff charge == COOLDOWN.
REQ-015 Eligible SHALL equal req & ready; a grant occurs iff eligible != 0 and at least one slot_en bit is 0 (registered values).
REQ-016 At most one grant SHALL issue per cycle; the free slot chosen SHALL be the lowest-indexed one with slot_en == 0.
REQ-017 Requester selection SHALL be round-robin from pointer rr_ptr; on a grant, rr_ptr SHALL become (winner+1) mod NUM_REQ; otherwise it is unchanged.
REQ-018 Grant latency SHALL be 1 cycle: inputs are sampled at edge N; at edge N+1 grant, grant_slot, slot_en[k], slot_owner[k] and the winner's charge reset all update together.
REQ-019 grant SHALL be 0 and grant_slot SHALL be 0 in every cycle without a grant.
REQ-020 slot_done[k] with slot_en[k]=1 SHALL clear slot_en[k] at the next edge; slot_done on an idle slot SHALL be ignored.
REQ-021 A slot freed by slot_done in cycle N SHALL NOT be allocated before the edge after it reads free (no same-cycle reuse).
REQ-022 When a requester is granted in the same cycle as tick, its charge SHALL go to 0 (the grant wins).
REQ-023 When all slots are busy, eligible requests SHALL wait: charge is held at COOLDOWN and no grant issues until a slot frees.
REQ-024 slot_owner[k] SHALL hold its last value after slot_en[k] clears.

Reset
REQ-025 While rst=1 at an edge: slot_en=0, slot_owner=0, grant=0, grant_slot=0, rr_ptr=0, all charges=COOLDOWN (charge_count=6).
REQ-026 rst asserted mid-operation SHALL abandon all active shots in one cycle; a grant already issued in that cycle is lost.

Configuration
REQ-027 Macro SHOT_PLAYER_PRIORITY_EN defined: an eligible requester 0 SHALL win over any other requester, and rr_ptr is unchanged when requester 0 wins by priority.
REQ-028 Macro SHOT_PLAYER_PRIORITY_EN undefined: requester 0 SHALL take part in plain round-robin only.

Structure
REQ-029 Package shot_pkg SHALL hold the default NUM_REQ, NUM_SLOTS and COOLDOWN values, the requester index constants (REQ_PLAYER=0) and the width localparams.
REQ-030 Requester selection SHALL be in sub-module rr_arbiter (inputs eligible and rr_ptr; outputs one-hot winner and valid); the slot pool and charge counters SHALL stay in shot_scheduler.

Verification
REQ-031 Reset, then req=0001 held with no tick -> grant=0001, grant_slot=0, slot_en=0001 one cycle after the first sampling edge; no second grant; charge_count=0.
REQ-032 Continue the REQ-031 case with 6 ticks -> charge_count steps 1..6; on the edge after the 6th tick, grant=0001 again with grant_slot=1.
REQ-033 Reset, then req=1111 held (macro undefined) -> grants 0001, 0010, 0100, 1000 on consecutive cycles into slots 0..3; then no grants.
REQ-034 All slots busy and req=0010 eligible, then slot_done=0100 -> slot_en[2] clears next edge; grant=0010 with grant_slot=2 one edge later.
REQ-035 Macro defined, rr_ptr=2, req=1101 eligible -> grant=0001 and rr_ptr stays 2; next grant goes to requester 2.
REQ-036 rst pulsed while slot_en=1011 -> next cycle slot_en=0, charge_count=6, grant=0.

Source files
------------

// File: rtl/shot_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module   : shot_pkg
// Purpose  : Shared defaults, requester indices and widths for the shot
//            scheduler and its round-robin arbiter.
// Contents : NUM_REQ_DEF, NUM_SLOTS_DEF, COOLDOWN_DEF  - default sizing
//            REQ_PLAYER / REQ_ALIEN*                   - requester indices
//            CHARGE_W, REQ_W_DEF, SLOT_W_DEF           - field widths
// Revision : 1.0 - initial release
// ============================================================================
package shot_pkg;

  localparam int NUM_REQ_DEF   = 4;
  localparam int NUM_SLOTS_DEF = 4;
  localparam int COOLDOWN_DEF  = 6;

  // Requester indices: the player always sits at index 0.
  localparam int REQ_PLAYER = 0;
  localparam int REQ_ALIEN1 = 1;
  localparam int REQ_ALIEN2 = 2;
  localparam int REQ_ALIEN3 = 3;

  // Charge counters are 3 bits wide to match the HUD charge_count field,
  // so COOLDOWN must not exceed 7.
  localparam int CHARGE_W   = 3;
  localparam int REQ_W_DEF  = $clog2(NUM_REQ_DEF);
  localparam int SLOT_W_DEF = $clog2(NUM_SLOTS_DEF);

endpackage : shot_pkg
`default_nettype wire

// File: rtl/shot_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin picker. Scans eligible requesters
//            starting at rr_ptr_i and wrapping; the first hit wins.
// Ports    : eligible_i [N]   - requesters allowed to win this cycle
//            rr_ptr_i   [PW]  - index searched first
//            winner_o   [N]   - one-hot winner (all zero when none)
//            valid_o          - at least one requester eligible
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import shot_pkg::*;
#(
  parameter  int N  = NUM_REQ_DEF,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  eligible_i,
  input  logic [PW-1:0] rr_ptr_i,
  output logic [N-1:0]  winner_o,
  output logic          valid_o
);

  always_comb begin
    int idx;
    idx      = 0;
    winner_o = '0;
    valid_o  = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr_i) + i;
      if (idx >= N) idx = idx - N;
      if (!valid_o && eligible_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/shot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : shot_scheduler
// Purpose  : Hands out shot engines (slots) to fire requesters. Each
//            requester must recharge for COOLDOWN ticks between grants; at
//            most one grant per cycle, lowest free slot first, requester
//            chosen round-robin.
// Ports    : s_clk        - system clock (rising edge)
//            rst          - synchronous active-high reset
//            tick         - one-cycle charge-advance strobe
//            req          - level fire requests, one per requester
//            slot_done    - per-slot pulse when a shot ends
//            grant        - one-hot, one-cycle grant pulse
//            grant_slot   - slot index carried by the current grant
//            slot_en      - slot busy flags (shot engine enables)
//            slot_owner   - flattened owner index per slot
//            charge_count - player (requester 0) charge level
// Config   : SHOT_PLAYER_PRIORITY_EN - when defined, an eligible player
//            beats every alien and leaves the round-robin pointer alone.
// Revision : 1.0 - initial release
// ============================================================================
module shot_scheduler
  import shot_pkg::*;
#(
  parameter  int NUM_REQ   = NUM_REQ_DEF,
  parameter  int NUM_SLOTS = NUM_SLOTS_DEF,
  parameter  int COOLDOWN  = COOLDOWN_DEF,
  localparam int REQ_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int SLOT_W    = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                       s_clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_SLOTS-1:0]       slot_done,
  output logic [NUM_REQ-1:0]         grant,
  output logic [SLOT_W-1:0]          grant_slot,
  output logic [NUM_SLOTS-1:0]       slot_en,
  output logic [NUM_SLOTS*REQ_W-1:0] slot_owner,
  output logic [2:0]                 charge_count
);

  localparam logic [CHARGE_W-1:0] C_FULL = CHARGE_W'(COOLDOWN);

  logic [REQ_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic [NUM_SLOTS-1:0]       slot_en_q, slot_en_d;
  logic [NUM_SLOTS*REQ_W-1:0] slot_owner_q, slot_owner_d;
  logic [NUM_REQ-1:0]         grant_q, grant_d;
  logic [SLOT_W-1:0]          grant_slot_q, grant_slot_d;
  logic [CHARGE_W-1:0]        charge_q [NUM_REQ];
  logic [CHARGE_W-1:0]        charge_d [NUM_REQ];

  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] arb_winner;
  logic [NUM_REQ-1:0] winner;
  logic               arb_valid;
  logic               prio_win;
  logic               slot_free;
  logic               do_grant;
  logic [SLOT_W-1:0]  free_idx;
  logic [REQ_W-1:0]   win_idx;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_ready
      assign ready[i] = (charge_q[i] == C_FULL);
    end
  endgenerate

  assign eligible = req & ready;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_arb (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .winner_o   (arb_winner),
    .valid_o    (arb_valid)
  );

`ifdef SHOT_PLAYER_PRIORITY_EN
  assign prio_win = eligible[REQ_PLAYER];
`else
  assign prio_win = 1'b0;
`endif

  // A priority win overrides the arbiter; arb_valid is already set because
  // the player is part of the eligible vector.
  always_comb begin
    winner = arb_winner;
    if (prio_win) begin
      winner             = '0;
      winner[REQ_PLAYER] = 1'b1;
    end
  end

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner[i]) win_idx = REQ_W'(i);
    end
  end

  // Lowest free slot: scan downwards so the last hit is the lowest index.
  always_comb begin
    slot_free = 1'b0;
    free_idx  = '0;
    for (int k = NUM_SLOTS - 1; k >= 0; k--) begin
      if (!slot_en_q[k]) begin
        slot_free = 1'b1;
        free_idx  = SLOT_W'(k);
      end
    end
  end

  // Only registered slot_en is consulted, so a slot released this cycle is
  // not handed out again until the following edge.
  assign do_grant = arb_valid && slot_free;

  always_comb begin
    // Done on an idle slot leaves it idle, so masking is harmless there.
    slot_en_d    = slot_en_q & ~slot_done;
    slot_owner_d = slot_owner_q;
    grant_d      = '0;
    grant_slot_d = '0;
    rr_ptr_d     = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      charge_d[i] = (tick && (charge_q[i] != C_FULL)) ? charge_q[i] + 1'b1
                                                       : charge_q[i];
    end
    if (do_grant) begin
      grant_d                                    = winner;
      grant_slot_d                               = free_idx;
      slot_en_d[free_idx]                        = 1'b1;
      slot_owner_d[int'(free_idx)*REQ_W +: REQ_W] = win_idx;
      // Grant beats a coincident tick.
      charge_d[win_idx]                          = '0;
      if (!prio_win) begin
        rr_ptr_d = (win_idx == REQ_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge s_clk) begin
    if (rst) begin
      rr_ptr_q     <= '0;
      slot_en_q    <= '0;
      slot_owner_q <= '0;
      grant_q      <= '0;
      grant_slot_q <= '0;
      for (int i = 0; i < NUM_REQ; i++) charge_q[i] <= C_FULL;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      slot_en_q    <= slot_en_d;
      slot_owner_q <= slot_owner_d;
      grant_q      <= grant_d;
      grant_slot_q <= grant_slot_d;
      for (int i = 0; i < NUM_REQ; i++) charge_q[i] <= charge_d[i];
    end
  end

  assign grant        = grant_q;
  assign grant_slot   = grant_slot_q;
  assign slot_en      = slot_en_q;
  assign slot_owner   = slot_owner_q;
  assign charge_count = 3'(charge_q[REQ_PLAYER]);

endmodule : shot_scheduler
`default_nettype wire

// File: tb/tb_shot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_shot_scheduler
// Purpose  : Self-checking bench for shot_scheduler (default sizing).
//            Expected grants are queued when stimulus is applied and popped
//            by a monitor when the DUT pulses grant; scenario tasks also
//            check slot flags and charge levels inline.
// Config   : SHOT_PLAYER_PRIORITY_EN selects the expected arbitration order.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shot_scheduler;

  logic       s_clk = 1'b0;
  logic       rst   = 1'b0;
  logic       tick  = 1'b0;
  logic [3:0] req   = '0;
  logic [3:0] slot_done = '0;
  logic [3:0] grant;
  logic [1:0] grant_slot;
  logic [3:0] slot_en;
  logic [7:0] slot_owner;
  logic [2:0] charge_count;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] s;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  bit   mon_en = 1'b0;

  shot_scheduler dut (
    .s_clk        (s_clk),
    .rst          (rst),
    .tick         (tick),
    .req          (req),
    .slot_done    (slot_done),
    .grant        (grant),
    .grant_slot   (grant_slot),
    .slot_en      (slot_en),
    .slot_owner   (slot_owner),
    .charge_count (charge_count)
  );

  always #5 s_clk = ~s_clk;

  // Scoreboard monitor: every grant pulse must match the oldest queued one;
  // idle cycles must carry grant_slot = 0.
  always @(negedge s_clk) begin
    if (mon_en) begin
      n_total++;
      if (grant !== 4'b0000) begin
        if (exp_q.size() == 0) begin
          $display("FAIL sb_unexpected: grant=%b slot=%0d, none expected", grant, grant_slot);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (grant !== e.g || grant_slot !== e.s)
            $display("FAIL sb_grant: grant=%b slot=%0d, want grant=%b slot=%0d", grant, grant_slot, e.g, e.s);
          else n_pass++;
        end
      end else begin
        if (grant_slot !== 2'd0) $display("FAIL sb_idle_slot: grant_slot=%0d, want 0", grant_slot);
        else n_pass++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge s_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; tick = 1'b0; slot_done = '0;
    cyc(2);
    n_total++; if (slot_en !== 4'b0000) $display("FAIL rst_slot_en: got %b want 0000", slot_en); else n_pass++;
    n_total++; if (slot_owner !== 8'h00) $display("FAIL rst_owner: got %h want 00", slot_owner); else n_pass++;
    n_total++; if (grant !== 4'b0000 || grant_slot !== 2'd0) $display("FAIL rst_grant: got %b/%0d want 0000/0", grant, grant_slot); else n_pass++;
    n_total++; if (charge_count !== 3'd6) $display("FAIL rst_charge: got %0d want 6", charge_count); else n_pass++;
    rst = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    req = 4'b0001;
    exp_q.push_back('{g: 4'b0001, s: 2'd0});
    cyc(1);
    n_total++; if (grant !== 4'b0001 || grant_slot !== 2'd0) $display("FAIL single_grant: got %b/%0d want 0001/0", grant, grant_slot); else n_pass++;
    n_total++; if (slot_en !== 4'b0001) $display("FAIL single_slot_en: got %b want 0001", slot_en); else n_pass++;
    n_total++; if (charge_count !== 3'd0) $display("FAIL single_charge: got %0d want 0", charge_count); else n_pass++;
    cyc(3);
    n_total++; if (slot_en !== 4'b0001) $display("FAIL single_no_regrant: slot_en=%b want 0001", slot_en); else n_pass++;
  endtask

  // Six ticks recharge the player; tick stays high on the grant cycle so the
  // grant must win over the increment.
  task automatic test_charge();
    tick = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      n_total++;
      if (charge_count !== 3'(k)) $display("FAIL charge_step%0d: got %0d want %0d", k, charge_count, k);
      else n_pass++;
    end
    n_total++; if (grant !== 4'b0000) $display("FAIL charge_early_grant: got %b want 0000", grant); else n_pass++;
    exp_q.push_back('{g: 4'b0001, s: 2'd1});
    cyc(1);
    tick = 1'b0;
    n_total++; if (grant !== 4'b0001 || grant_slot !== 2'd1) $display("FAIL charge_regrant: got %b/%0d want 0001/1", grant, grant_slot); else n_pass++;
    n_total++; if (charge_count !== 3'd0) $display("FAIL charge_grant_wins: got %0d want 0", charge_count); else n_pass++;
    n_total++; if (slot_en !== 4'b0011) $display("FAIL charge_slot_en: got %b want 0011", slot_en); else n_pass++;
    req = '0;
    cyc(1);
  endtask

  task automatic test_round_robin();
    logic [3:0] g_exp;
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) exp_q.push_back('{g: 4'(1 << i), s: 2'(i)});
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      g_exp = 4'(1 << i);
      n_total++;
      if (grant !== g_exp || grant_slot !== 2'(i)) $display("FAIL rr_grant%0d: got %b/%0d want %b/%0d", i, grant, grant_slot, g_exp, i);
      else n_pass++;
    end
    cyc(3);
    n_total++; if (slot_en !== 4'b1111) $display("FAIL rr_slot_en: got %b want 1111", slot_en); else n_pass++;
    n_total++; if (slot_owner !== 8'b11_10_01_00) $display("FAIL rr_owner: got %b want 11100100", slot_owner); else n_pass++;
  endtask

  // Pool full: requester 1 recharges and waits; player charge saturates.
  task automatic test_slot_reuse();
    req = 4'b0010; tick = 1'b1;
    cyc(8);
    tick = 1'b0;
    n_total++; if (charge_count !== 3'd6) $display("FAIL full_saturate: got %0d want 6", charge_count); else n_pass++;
    cyc(2);
    n_total++; if (grant !== 4'b0000) $display("FAIL full_wait: got %b want 0000", grant); else n_pass++;
    slot_done = 4'b0100;
    cyc(1);
    slot_done = '0;
    n_total++; if (slot_en !== 4'b1011) $display("FAIL reuse_clear: got %b want 1011", slot_en); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL reuse_same_cycle: got %b want 0000", grant); else n_pass++;
    exp_q.push_back('{g: 4'b0010, s: 2'd2});
    cyc(1);
    req = '0;
    n_total++; if (grant !== 4'b0010 || grant_slot !== 2'd2) $display("FAIL reuse_grant: got %b/%0d want 0010/2", grant, grant_slot); else n_pass++;
    n_total++; if (slot_en !== 4'b1111) $display("FAIL reuse_slot_en: got %b want 1111", slot_en); else n_pass++;
  endtask

  task automatic test_reset_mid();
    slot_done = 4'b0100;
    cyc(1);
    slot_done = '0;
    n_total++; if (slot_en !== 4'b1011) $display("FAIL mid_setup: got %b want 1011", slot_en); else n_pass++;
    // The player is charged and a slot is free, but reset swallows the grant.
    rst = 1'b1; req = 4'b0001;
    cyc(1);
    rst = 1'b0;
    n_total++; if (slot_en !== 4'b0000) $display("FAIL mid_slot_en: got %b want 0000", slot_en); else n_pass++;
    n_total++; if (charge_count !== 3'd6) $display("FAIL mid_charge: got %0d want 6", charge_count); else n_pass++;
    n_total++; if (grant !== 4'b0000) $display("FAIL mid_grant_lost: got %b want 0000", grant); else n_pass++;
    exp_q.push_back('{g: 4'b0001, s: 2'd0});
    cyc(1);
    req = '0;
    n_total++; if (grant !== 4'b0001 || grant_slot !== 2'd0) $display("FAIL mid_regrant: got %b/%0d want 0001/0", grant, grant_slot); else n_pass++;
    slot_done = 4'b0010;
    cyc(1);
    slot_done = '0;
    n_total++; if (slot_en !== 4'b0001) $display("FAIL idle_done: got %b want 0001", slot_en); else n_pass++;
  endtask

  // Walk rr_ptr to 2 via a grant to requester 1, then offer 1101.
  task automatic test_arbitration();
    exp_t seq [3];
`ifdef SHOT_PLAYER_PRIORITY_EN
    seq[0] = '{g: 4'b0001, s: 2'd1};
    seq[1] = '{g: 4'b0100, s: 2'd2};
    seq[2] = '{g: 4'b1000, s: 2'd3};
`else
    seq[0] = '{g: 4'b0100, s: 2'd1};
    seq[1] = '{g: 4'b1000, s: 2'd2};
    seq[2] = '{g: 4'b0001, s: 2'd3};
`endif
    rst = 1'b1; cyc(1); rst = 1'b0;
    req = 4'b0010;
    exp_q.push_back('{g: 4'b0010, s: 2'd0});
    cyc(1);
    n_total++; if (grant !== 4'b0010) $display("FAIL arb_setup: got %b want 0010", grant); else n_pass++;
    req = 4'b1101;
    for (int i = 0; i < 3; i++) exp_q.push_back(seq[i]);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      n_total++;
      if (grant !== seq[i].g || grant_slot !== seq[i].s)
        $display("FAIL arb_order%0d: got %b/%0d want %b/%0d", i, grant, grant_slot, seq[i].g, seq[i].s);
      else n_pass++;
    end
    req = '0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_charge();
    test_round_robin();
    test_slot_reuse();
    test_reset_mid();
    test_arbitration();
    cyc(2);
    n_total++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d expected grants never seen, want 0", exp_q.size());
    else n_pass++;
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule : tb_shot_scheduler
`default_nettype wire
